rv32_regfile_sb: RTL and testbench
==================================

Name: rv32_regfile_sb

Overview:
- Parametrised successor to the core's 2R1W register file: configurable register width and count, N read ports, 2 write ports.
- Adds an integrated scoreboard with per-register busy bits, so the issue stage can detect RAW hazards against in-flight writebacks.
- Sits between decode/issue (reads, busy set) and the writeback stage (two retire lanes, e.g. ALU and LSU).

Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers, power of two, >= 2
- AW, 5, address width; must equal clog2(NREGS)
- NRD, 2, number of read ports, 1..4

Ports:
- clk_i  in  1  core clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- rs_addr_i  in  NRD*AW  read addresses; port k = bits [k*AW +: AW]
- rs_val_o  out  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
- rs_busy_o  out  NRD  port k address has a pending write
- we_i  in  2  write enables, lanes 0 and 1
- wr_addr_i  in  2*AW  write addresses per lane
- wr_data_i  in  2*XLEN  write data per lane
- sb_set_i  in  1  mark sb_addr_i busy (instruction issued with rd)
- sb_addr_i  in  AW  destination register being issued
- sb_flush_i  in  1  clear all busy bits (pipeline flush)
- busy_cnt_o  out  AW+1  number of registers currently busy

Behaviour:
- Reset:
  - Asynchronous; all registers and all busy bits cleared.
  - rs_val_o = 0, rs_busy_o = 0, busy_cnt_o = 0 while rst_n_i is low and after release.
- Register x0:
  - Reads always 0; never busy.
  - Writes to address 0 are dropped; sb_set_i with address 0 is ignored.
- Writes:
  - Take effect at the rising edge.
  - Both lanes to the same nonzero address in the same cycle: lane 1 wins.
- Reads:
  - Combinational from the array; zero latency.
  - No same-cycle bypass unless the optional feature is enabled.
- Scoreboard, per busy bit:
  - Next state evaluated in priority order (highest first): sb_flush_i -> 0; sb_set_i on that address -> 1; we_i on any lane with that address -> 0; otherwise hold.
  - Set beats writeback clear in the same cycle: the newer producer owns the register.
  - Flush beats set.
- rs_busy_o[k]: combinational from the busy bits registered at the current edge.
- busy_cnt_o:
  - Registered counter updated every cycle to the popcount of the next busy vector.
  - Range 0..NREGS-1; maintained incrementally (+1 per newly set bit, -1 per cleared bit), no full popcount tree.
  - Two distinct addresses cleared in one cycle: -2.
  - Set plus clear in one cycle: net change, never a transient.
- Illegal use: read port addresses may alias one another freely; no restriction.
- Reset asserted mid-operation: immediate clear regardless of pending writes or set.

Optional Feature:
- Macro: API_REGFILE_BYPASS_EN.
- Defined:
  - Each read port compares its address against both write lanes.
  - On match (nonzero address, we_i set), rs_val_o returns wr_data_i combinationally; lane 1 has priority.
  - rs_busy_o[k] is forced to 0 for that port in that cycle, since the value is available now.
- Undefined:
  - Reads return the array contents (value visible the cycle after the write edge).
  - rs_busy_o reflects the busy bit unchanged.

Test Plan:
- Reset check: hold rst_n_i low, drive we_i=2'b11 to addresses 5/6 -> after release rs_val_o=0 for reads of x5, x6; busy_cnt_o=0.
- Dual write, same address: lane0 writes x7=0x11111111, lane1 writes x7=0x22222222 in one cycle -> next cycle read x7 = 0x22222222.
- x0 writes: lane0 writes x0=0xDEADBEEF with sb_set_i on x0 -> read x0 = 0; rs_busy_o=0; busy_cnt_o unchanged.
- Scoreboard lifecycle: sb_set_i x3 -> rs_busy_o=1, busy_cnt_o=1; writeback x3=0xA5 -> busy 0, count 0, read 0xA5.
- Simultaneous set and clear plus flush:
  - Set x4 with a lane0 write to x4 in the same cycle -> x4 remains busy, count 1.
  - Then sb_flush_i together with sb_set_i x9 -> all busy 0, count 0.
- Bypass, with API_REGFILE_BYPASS_EN: read x8 while lane1 writes x8=0x12345678 -> same-cycle rs_val_o=0x12345678, rs_busy_o=0. Without the macro -> old value in that cycle, new value the next cycle.

Source files
------------

// File: rtl/rv32_regfile_sb.sv
// rv32_regfile_sb: NRD-read / 2-write register file with per-register busy scoreboard.
// Define API_REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module rv32_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_val_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [1:0]          we_i,
  input  logic [2*AW-1:0]     wr_addr_i,
  input  logic [2*XLEN-1:0]   wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  input  logic                sb_flush_i,
  output logic [AW:0]         busy_cnt_o
);
  localparam int CW = AW + 1;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy, busy_n;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wa0, wa1;
  logic             set_v, inc, clr0, clr1;
  assign wa0   = wr_addr_i[0 +: AW];
  assign wa1   = wr_addr_i[AW +: AW];
  assign set_v = sb_set_i && sb_addr_i != '0;
  // Count deltas mirror busy_n: a set on the same address masks a clear, and a shared lane address clears once.
  assign inc  = set_v && !busy[sb_addr_i];
  assign clr0 = we_i[0] && wa0 != '0 && busy[wa0] && !(set_v && sb_addr_i == wa0);
  assign clr1 = we_i[1] && wa1 != '0 && busy[wa1] && !(set_v && sb_addr_i == wa1) && !(we_i[0] && wa0 == wa1);
  always_comb begin
    busy_n = busy;
    for (int i = 1; i < NREGS; i++)
      busy_n[i] = sb_flush_i ? 1'b0 :
                  (set_v && sb_addr_i == AW'(i)) ? 1'b1 :
                  ((we_i[0] && wa0 == AW'(i)) || (we_i[1] && wa1 == AW'(i))) ? 1'b0 : busy[i];
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy <= '0;
      cnt  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_n;
      cnt  <= sb_flush_i ? '0 : cnt + CW'(inc) - CW'(clr0) - CW'(clr1);
      if (we_i[0] && wa0 != '0) regs[wa0] <= wr_data_i[0 +: XLEN];
      if (we_i[1] && wa1 != '0) regs[wa1] <= wr_data_i[XLEN +: XLEN];
    end
  end
  assign busy_cnt_o = cnt;
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rs_addr_i[k*AW +: AW];
`ifdef API_REGFILE_BYPASS_EN
    logic h0, h1;
    assign h0 = we_i[0] && wa0 == ra && ra != '0;
    assign h1 = we_i[1] && wa1 == ra && ra != '0;
    assign rs_val_o[k*XLEN +: XLEN] = h1 ? wr_data_i[XLEN +: XLEN] : h0 ? wr_data_i[0 +: XLEN] : regs[ra];
    assign rs_busy_o[k] = busy[ra] && !(h0 || h1);
`else
    assign rs_val_o[k*XLEN +: XLEN] = regs[ra];
    assign rs_busy_o[k] = busy[ra];
`endif
  end
endmodule

// File: tb/tb_rv32_regfile_sb.sv
// tb_rv32_regfile_sb: directed checks of reads, writes, x0 handling, scoreboard and busy count.
module tb_rv32_regfile_sb;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [9:0]  rs_addr_i = '0;
  logic [63:0] rs_val_o;
  logic [1:0]  rs_busy_o;
  logic [1:0]  we_i = '0;
  logic [9:0]  wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic        sb_set_i = 1'b0;
  logic [4:0]  sb_addr_i = '0;
  logic        sb_flush_i = 1'b0;
  logic [5:0]  busy_cnt_o;
  int n_cmp = 0;
  int n_err = 0;
`ifdef API_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rv32_regfile_sb dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rs_addr_i(rs_addr_i), .rs_val_o(rs_val_o),
    .rs_busy_o(rs_busy_o), .we_i(we_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i), .sb_flush_i(sb_flush_i), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we_i = '0; sb_set_i = 1'b0; sb_flush_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr_i = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    we_i = we; wr_addr_i = {a1, a0}; wr_data_i = {d1, d0};
  endtask

  task automatic sbset(input logic [4:0] a);
    sb_set_i = 1'b1; sb_addr_i = a;
  endtask

  initial begin
    wr(2'b11, 5'd5, 32'hAAAA5555, 5'd6, 32'h6666CCCC);
    sbset(5'd5);
    rs_addr_i = {5'd6, 5'd5};
    step(); step();
    check("rst_hold_val0", rs_val_o[31:0], 32'h0);
    check("rst_hold_cnt", 32'(busy_cnt_o), 32'd0);
    rst_n_i = 1'b1; idle();
    step();
    rd(5'd5, 5'd6);
    check("rst_x5", rs_val_o[31:0], 32'h0);
    check("rst_x6", rs_val_o[63:32], 32'h0);
    check("rst_busy", 32'(rs_busy_o), 32'h0);
    check("rst_cnt", 32'(busy_cnt_o), 32'd0);

    wr(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222);
    rd(5'd1, 5'd2);
    step(); idle();
    rd(5'd7, 5'd7);
    check("dual_wr_x7", rs_val_o[31:0], 32'h22222222);
    check("alias_x7", rs_val_o[63:32], 32'h22222222);

    wr(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
    sbset(5'd0);
    step(); idle();
    rd(5'd1, 5'd0);
    check("x0_val", rs_val_o[63:32], 32'h0);
    check("x0_busy", 32'(rs_busy_o[1]), 32'h0);
    check("x0_cnt", 32'(busy_cnt_o), 32'd0);

    sbset(5'd3);
    step(); idle();
    rd(5'd3, 5'd1);
    check("sb_set_busy", 32'(rs_busy_o[0]), 32'h1);
    check("sb_set_cnt", 32'(busy_cnt_o), 32'd1);
    check("sb_set_val", rs_val_o[31:0], 32'h0);
    wr(2'b01, 5'd3, 32'h000000A5, 5'd0, 32'h0);
    rd(5'd3, 5'd1);
    check("wb_same_val", rs_val_o[31:0], BYP ? 32'hA5 : 32'h0);
    check("wb_same_busy", 32'(rs_busy_o[0]), BYP ? 32'h0 : 32'h1);
    step(); idle();
    rd(5'd3, 5'd1);
    check("wb_busy", 32'(rs_busy_o[0]), 32'h0);
    check("wb_cnt", 32'(busy_cnt_o), 32'd0);
    check("wb_val", rs_val_o[31:0], 32'hA5);

    rd(5'd1, 5'd2);
    sbset(5'd4);
    wr(2'b01, 5'd4, 32'h00000044, 5'd0, 32'h0);
    step(); idle();
    rd(5'd4, 5'd1);
    check("set_clr_busy", 32'(rs_busy_o[0]), 32'h1);
    check("set_clr_cnt", 32'(busy_cnt_o), 32'd1);
    check("set_clr_val", rs_val_o[31:0], 32'h44);

    sbset(5'd10); step();
    sbset(5'd11); step(); idle();
    check("cnt3", 32'(busy_cnt_o), 32'd3);
    rd(5'd1, 5'd2);
    wr(2'b11, 5'd10, 32'h0A, 5'd11, 32'h0B);
    step(); idle();
    check("dual_clr_cnt", 32'(busy_cnt_o), 32'd1);
    sbset(5'd12);
    wr(2'b01, 5'd4, 32'h00000045, 5'd0, 32'h0);
    step(); idle();
    rd(5'd4, 5'd12);
    check("net_cnt", 32'(busy_cnt_o), 32'd1);
    check("net_busy", 32'(rs_busy_o), 32'h2);

    sb_flush_i = 1'b1; sbset(5'd9);
    step(); idle();
    rd(5'd9, 5'd12);
    check("flush_cnt", 32'(busy_cnt_o), 32'd0);
    check("flush_busy", 32'(rs_busy_o), 32'h0);

    rd(5'd1, 5'd2);
    wr(2'b01, 5'd8, 32'h0BADF00D, 5'd0, 32'h0);
    sbset(5'd8);
    step(); idle();
    wr(2'b10, 5'd0, 32'h0, 5'd8, 32'h12345678);
    rd(5'd1, 5'd8);
    check("byp_val", rs_val_o[63:32], BYP ? 32'h12345678 : 32'h0BADF00D);
    check("byp_busy", 32'(rs_busy_o[1]), BYP ? 32'h0 : 32'h1);
    step(); idle();
    rd(5'd1, 5'd8);
    check("byp_next_val", rs_val_o[63:32], 32'h12345678);
    check("byp_next_busy", 32'(rs_busy_o[1]), 32'h0);
    check("byp_next_cnt", 32'(busy_cnt_o), 32'd0);

    sbset(5'd13); step();
    wr(2'b01, 5'd14, 32'h77, 5'd0, 32'h0);
    #2 rst_n_i = 1'b0;
    rd(5'd7, 5'd13);
    check("midrst_cnt", 32'(busy_cnt_o), 32'd0);
    check("midrst_val", rs_val_o[31:0], 32'h0);
    check("midrst_busy", 32'(rs_busy_o), 32'h0);
    step(); idle();
    rst_n_i = 1'b1;
    step();
    rd(5'd14, 5'd13);
    check("postrst_x14", rs_val_o[31:0], 32'h0);
    check("postrst_cnt", 32'(busy_cnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
